// File: rtl/wave_capture_buffer.sv
// wave_capture_buffer: soft logic analyser capturing NUM_CH x CH_W probes into a DEPTH-deep circular buffer
//
// Optional build macro: CAPTURE_DECIM_EN (enables the decim-driven strobe decimator)
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   probe_data      packed probe channels, ch0 in the low CH_W bits
//   sample_en       sample strobe from the caller
//   arm, abort      start capture / return to IDLE (abort wins)
//   trig_mode       00 rising, 01 falling, 10 immediate, 11 external
//   trig_ch         channel compared for edge triggers
//   trig_level      unsigned edge threshold
//   ext_trig        external trigger level
//   pretrig_len     samples kept before the trigger
//   decim           extra decimation ratio (only with CAPTURE_DECIM_EN)
//   state, done     0 IDLE, 1 PRE, 2 WAIT, 3 POST, 4 DONE; done high in DONE
//   trig_addr       physical buffer address of the trigger sample
//   rd_en, rd_addr  read request, logical index (0 = oldest sample)
//   rd_data         read data, valid with rd_valid one cycle after rd_en
module wave_capture_buffer #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 12,
    parameter int DEPTH  = 1024,
    parameter int AW     = $clog2(DEPTH),
    parameter int TW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH*CH_W-1:0] probe_data,
    input  logic                   sample_en,
    input  logic                   arm,
    input  logic                   abort,
    input  logic [1:0]             trig_mode,
    input  logic [TW-1:0]          trig_ch,
    input  logic [CH_W-1:0]        trig_level,
    input  logic                   ext_trig,
    input  logic [AW-1:0]          pretrig_len,
    input  logic [15:0]            decim,
    output logic [2:0]             state,
    output logic                   done,
    output logic [AW-1:0]          trig_addr,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [NUM_CH*CH_W-1:0] rd_data,
    output logic                   rd_valid
);
    localparam int W = NUM_CH * CH_W;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr_q, pre_cnt_q, plen_q, trig_addr_q;
    logic [AW:0]     post_cnt_q;
    logic [1:0]      mode_q;
    logic [TW-1:0]   ch_q;
    logic [CH_W-1:0] level_q, prev_q;
    logic            prev_valid_q, done_q;
    logic            rd_valid_q, rd_ok_q;
    logic [W-1:0]    ram_q;
    logic [W-1:0]    mem [DEPTH];

    logic            strobe, pre_full, we, trig_hit;
    logic [CH_W-1:0] cur;
    logic [AW:0]     post_tgt;
    logic [AW-1:0]   start_ptr;

`ifdef CAPTURE_DECIM_EN
    logic [15:0] dec_cnt_q;
    // Counts sample_en pulses; a strobe fires when the count equals decim.
    always_ff @(posedge clk) begin
        if (rst || arm) begin
            dec_cnt_q <= '0;
        end else if (sample_en) begin
            dec_cnt_q <= (dec_cnt_q == decim) ? '0 : dec_cnt_q + 16'd1;
        end
    end
    assign strobe = sample_en && (dec_cnt_q == decim);
`else
    logic unused_decim;
    assign unused_decim = ^decim;
    assign strobe       = sample_en;
`endif

    assign cur       = probe_data[ch_q*CH_W +: CH_W];
    assign pre_full  = (pre_cnt_q == plen_q);
    assign post_tgt  = (AW+1)'(DEPTH) - {1'b0, plen_q};
    assign start_ptr = trig_addr_q - plen_q;
    // PRE stops writing once the pre-trigger quota is met (covers pretrig_len=0).
    assign we = strobe && ((state_q == S_PRE && !pre_full) || state_q == S_WAIT || state_q == S_POST);

    always_comb begin
        trig_hit = (mode_q == 2'b00) ? (prev_valid_q && prev_q <  level_q && cur >= level_q) :
                   (mode_q == 2'b01) ? (prev_valid_q && prev_q >= level_q && cur <  level_q) :
                   (mode_q == 2'b10) ? 1'b1 : ext_trig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            pre_cnt_q    <= '0;
            post_cnt_q   <= '0;
            plen_q       <= '0;
            trig_addr_q  <= '0;
            mode_q       <= '0;
            ch_q         <= '0;
            level_q      <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else if (abort) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            if (we) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                prev_q       <= cur;
                prev_valid_q <= 1'b1;
            end
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (arm) begin
                        state_q      <= S_PRE;
                        done_q       <= 1'b0;
                        wr_ptr_q     <= '0;
                        pre_cnt_q    <= '0;
                        prev_valid_q <= 1'b0;
                        mode_q       <= trig_mode;
                        ch_q         <= trig_ch;
                        level_q      <= trig_level;
                        plen_q       <= pretrig_len;
                    end
                end
                S_PRE: begin
                    if (pre_full) begin
                        state_q <= S_WAIT;
                    end else if (strobe) begin
                        pre_cnt_q <= pre_cnt_q + 1'b1;
                        if (pre_cnt_q + 1'b1 == plen_q) state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // The trigger sample is the first post sample; a single-sample
                    // post window completes immediately.
                    if (strobe && trig_hit) begin
                        trig_addr_q <= wr_ptr_q;
                        post_cnt_q  <= (AW+1)'(1);
                        state_q     <= (post_tgt == (AW+1)'(1)) ? S_DONE : S_POST;
                        done_q      <= (post_tgt == (AW+1)'(1));
                    end
                end
                S_POST: begin
                    if (strobe) begin
                        post_cnt_q <= post_cnt_q + 1'b1;
                        if (post_cnt_q + 1'b1 == post_tgt) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Readback flags; data is zeroed unless the request was made in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_ok_q    <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            rd_ok_q    <= rd_en && (state_q == S_DONE);
        end
    end

    // Simple dual-port RAM without reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr_q] <= probe_data;
        if (rd_en) ram_q <= mem[start_ptr + rd_addr];
    end

    assign state     = state_q;
    assign done      = done_q;
    assign trig_addr = trig_addr_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_ok_q ? ram_q : '0;
endmodule

// File: tb/tb_wave_capture_buffer.sv
// tb_wave_capture_buffer: directed self-checking bench for wave_capture_buffer (DEPTH=16)
module tb_wave_capture_buffer;
    localparam int W = 48;

    logic          clk = 1'b0;
    logic          rst, sample_en, arm, abort, ext_trig, rd_en;
    logic [W-1:0]  probe_data, rd_data;
    logic [1:0]    trig_mode, trig_ch;
    logic [11:0]   trig_level;
    logic [3:0]    pretrig_len, rd_addr, trig_addr;
    logic [15:0]   decim;
    logic [2:0]    state;
    logic          done, rd_valid;
    int            n_chk = 0;
    int            n_fail = 0;

    wave_capture_buffer #(.NUM_CH(4), .CH_W(12), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .probe_data(probe_data), .sample_en(sample_en),
        .arm(arm), .abort(abort), .trig_mode(trig_mode), .trig_ch(trig_ch),
        .trig_level(trig_level), .ext_trig(ext_trig), .pretrig_len(pretrig_len),
        .decim(decim), .state(state), .done(done), .trig_addr(trig_addr),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] mk1(input int k);
        logic [11:0] c0;
        c0 = 12'(32'h400 + 32'h100 * k);
        return {12'(k), 12'hABC, 12'(k * 3), c0};
    endfunction

    function automatic logic [47:0] mk3(input int j);
        return {12'h111, 12'h222, 12'(j), 12'(32'h800 + j)};
    endfunction

    initial begin
        rst = 1; arm = 0; abort = 0; sample_en = 0; ext_trig = 0; rd_en = 0; rd_addr = 0;
        probe_data = '0; trig_mode = 2'b00; trig_ch = 0; trig_level = 12'h800;
        pretrig_len = 4; decim = 0;
        tick(); tick();
        chk("rst_state", state, 0);
        chk("rst_done", done, 0);
        chk("rst_trig_addr", trig_addr, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 0;

        // Rising edge on ch0, 4 pre-trigger samples
        arm = 1; tick(); arm = 0;
        chk("t1_arm_pre", state, 1);
        for (int k = 0; k < 16; k++) begin
            probe_data = mk1(k); sample_en = 1; tick();
            if (k == 3) chk("t1_wait", state, 2);
            if (k == 4) begin
                chk("t1_post", state, 3);
                chk("t1_trig_addr", trig_addr, 4);
            end
            if (k == 14) chk("t1_still_post", state, 3);
            if (k == 15) begin
                chk("t1_done_state", state, 4);
                chk("t1_done", done, 1);
            end
        end
        sample_en = 0;
        for (int i = 0; i < 16; i++) begin
            rd_en = 1; rd_addr = 4'(i); tick();
            chk("t1_rd_valid", rd_valid, 1);
            chk("t1_rd_data", rd_data, mk1(i));
        end
        rd_en = 0; tick();
        chk("t1_rd_idle", rd_valid, 0);

        // Immediate trigger, no pre-trigger samples
        trig_mode = 2'b10; pretrig_len = 0; trig_ch = 0;
        arm = 1; tick(); arm = 0;
        chk("t3_pre", state, 1);
        chk("t3_done_drop", done, 0);
        tick();
        chk("t3_wait", state, 2);
        for (int j = 0; j < 16; j++) begin
            probe_data = mk3(j); sample_en = 1; tick();
            if (j == 0) begin
                chk("t3_post", state, 3);
                chk("t3_trig_addr", trig_addr, 0);
            end
            if (j == 14) chk("t3_still_post", state, 3);
            if (j == 15) chk("t3_done", state, 4);
        end
        sample_en = 0;
        rd_en = 1; rd_addr = 0; tick();
        chk("t3_rd0", rd_data, mk3(0));
        rd_addr = 15; tick();
        chk("t3_rd15", rd_data, mk3(15));
        rd_en = 0;

        // Falling edge on ch1; config changes after arm must be ignored
        trig_mode = 2'b01; trig_ch = 1; trig_level = 12'h800; pretrig_len = 0;
        arm = 1; tick(); arm = 0;
        trig_mode = 2'b10; trig_level = 12'h000; trig_ch = 0;
        tick();
        chk("t2_wait", state, 2);
        probe_data = {24'h0, 12'h100, 12'h900}; sample_en = 1; tick();
        chk("t2_first_below", state, 2);
        probe_data = {24'h0, 12'hFFF, 12'h700}; tick();
        chk("t2_ch0_fall_ignored", state, 2);
        probe_data = {24'h0, 12'h100, 12'h600}; tick();
        chk("t2_post", state, 3);
        chk("t2_trig_addr", trig_addr, 2);
        for (int m = 1; m < 16; m++) begin
            probe_data = {12'(m), 24'h0, 12'h000}; tick();
            if (m == 14) chk("t2_still_post", state, 3);
            if (m == 15) chk("t2_done", state, 4);
        end
        sample_en = 0;
        rd_en = 1; rd_addr = 0; tick();
        chk("t2_rd0", rd_data, {24'h0, 12'h100, 12'h600});
        rd_addr = 15; tick();
        chk("t2_rd15", rd_data, {12'd15, 36'h0});
        rd_en = 0;

        // Arm ignored in WAIT; abort beats arm; reads outside DONE return zero
        trig_mode = 2'b11; pretrig_len = 0; ext_trig = 0;
        arm = 1; tick(); arm = 0;
        chk("t4_pre", state, 1);
        tick();
        chk("t4_wait", state, 2);
        arm = 1; tick();
        chk("t4_arm_ignored", state, 2);
        abort = 1; tick(); arm = 0; abort = 0;
        chk("t4_abort_state", state, 0);
        chk("t4_abort_done", done, 0);
        rd_en = 1; rd_addr = 3; tick(); rd_en = 0;
        chk("t4_idle_rd_valid", rd_valid, 1);
        chk("t4_idle_rd_data", rd_data, 0);

        // Reset during POST
        trig_mode = 2'b10; pretrig_len = 3;
        arm = 1; tick(); arm = 0;
        probe_data = 48'h123; sample_en = 1;
        tick(); tick(); tick();
        chk("t5_wait", state, 2);
        tick();
        chk("t5_post", state, 3);
        chk("t5_trig_addr", trig_addr, 3);
        rd_en = 1; tick();
        chk("t5_post_rd_valid", rd_valid, 1);
        chk("t5_post_rd_data", rd_data, 0);
        rst = 1; tick();
        chk("t5_rst_state", state, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_trig_addr", trig_addr, 0);
        chk("t5_rst_rd_valid", rd_valid, 0);
        chk("t5_rst_rd_data", rd_data, 0);
        rst = 0; rd_en = 0; sample_en = 0;

`ifdef CAPTURE_DECIM_EN
        // Decimate by 3: ramp of step 1 is stored with step 3
        decim = 2; trig_mode = 2'b10; pretrig_len = 0; trig_ch = 0;
        arm = 1; tick(); arm = 0;
        tick();
        chk("t6_wait", state, 2);
        for (int n = 0; n < 48; n++) begin
            probe_data = {36'h0, 12'(n)}; sample_en = 1; tick();
            if (n == 46) chk("t6_still_post", state, 3);
            if (n == 47) chk("t6_done", state, 4);
        end
        sample_en = 0;
        for (int i = 0; i < 16; i += 5) begin
            rd_en = 1; rd_addr = 4'(i); tick();
            chk("t6_rd", rd_data, {36'h0, 12'(3 * i + 2)});
        end
        rd_en = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
